reg_dump: RTL
=============

# reg_dump

Sequential read-out engine for the 8-bit processor's `reg_file`. When started, it drives the register file's two read-address ports, walking every register in pairs, and captures `REGOUT1`/`REGOUT2`. It then streams each register as an (address, data) beat over a valid/ready output. It is the reader end of the register-file interface and sits beside the datapath for debug and trace dumps.

## Interface
Parameters:
- `NREG`, 8: number of registers dumped. Must be even and ≤ 2^`AW`.
- `AW`, 3: register address width.
- `DW`, 8: register data width.

Ports:
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RESET`  in  1: asynchronous, active-high reset.
- `START`  in  1: begin a dump. Sampled only in IDLE.
- `BUSY`  out  1: high from the cycle after START is accepted until the cycle DONE is asserted, inclusive.
- `DONE`  out  1: one-cycle pulse after the last beat is accepted.
- `READREG1`  out  `AW`: read address to `reg_file` port 1 (even register).
- `READREG2`  out  `AW`: read address to `reg_file` port 2 (odd register).
- `REGOUT1`  in  `DW`: `reg_file` read data 1.
- `REGOUT2`  in  `DW`: `reg_file` read data 2.
- `OUT_VALID`  out  1: output beat valid.
- `OUT_READY`  in  1: consumer accepts the beat.
- `OUT_ADDR`  out  `AW`: register index of the current beat.
- `OUT_DATA`  out  `DW`: register value of the current beat.

## Operation
- States: IDLE, ISSUE, SEND0, SEND1, FIN.
- IDLE: if `START`=1, load pair index k=0 and go to ISSUE. Otherwise stay.
- ISSUE: `READREG1`=2k and `READREG2`=2k+1 are driven from registers for the full cycle, which absorbs `reg_file` read delay. On the exiting edge, capture `REGOUT1` into `buf0` and `REGOUT2` into `buf1`, then go to SEND0.
- SEND0: `OUT_VALID`=1, `OUT_ADDR`=2k, `OUT_DATA`=`buf0`. On `OUT_READY`=1, go to SEND1.
- SEND1: `OUT_VALID`=1, `OUT_ADDR`=2k+1, `OUT_DATA`=`buf1`. On `OUT_READY`=1:
  - if k=`NREG`/2−1, go to FIN;
  - otherwise k←k+1 and go to ISSUE.
- FIN: `DONE`=1 for one cycle, then go to IDLE.
- Handshake rules:
  - `OUT_VALID` never depends combinationally on `OUT_READY`.
  - While `OUT_VALID`=1 and `OUT_READY`=0, `OUT_ADDR` and `OUT_DATA` hold stable.
  - No beat is dropped or duplicated.
- Read and capture rules:
  - `READREG1` and `READREG2` hold their last values outside ISSUE.
  - `reg_file` is never written by this block.
- Consistency: each pair is a snapshot at its capture edge. A CPU write to a register before that register's ISSUE is visible in the dump; a write after it is not.
- `START` while BUSY is ignored; there is no queueing.
- Reset values (asserted immediately and asynchronously): state=IDLE, k=0, `BUSY`=0, `DONE`=0, `OUT_VALID`=0, `OUT_ADDR`=0, `OUT_DATA`=0, `READREG1`=0, `READREG2`=0, `buf0`=`buf1`=0.
- `RESET` mid-dump aborts the dump: no DONE and no further beats. The next START restarts at address 0.

## Timing
- Edge E0 samples `START`. ISSUE for pair k occupies the cycle after edge E(3k) when `OUT_READY` is held high.
- First `OUT_VALID` occurs in the cycle after E1, i.e. a latency of 2 cycles from the START edge.
- Throughput with no backpressure: 2 beats per 3 cycles.
- With `NREG`=8 and `OUT_READY`=1: `DONE` is high in the cycle after E12, and `BUSY` falls after E13.
- Each cycle of `OUT_READY`=0 while valid delays DONE by exactly one cycle.

## Structure
- Shared package `reg_dump_pkg` holds:
  - the state enum (IDLE=0, ISSUE=1, SEND0=2, SEND1=3, FIN=4, 3-bit encoding);
  - default `AW`/`DW`/`NREG` constants, shared with `reg_file`.
- Single module with no sub-module. The FSM, pair counter and 2-entry capture buffer are small enough to live together.

## Test plan
- Preload r0..r7 = 8'h10..8'h17 through the `reg_file` write port, then pulse START with `OUT_READY`=1:
  - 8 beats: addr 0..7, data 8'h10..8'h17 in order;
  - DONE in the cycle after E12;
  - BUSY low after E13.
- Same preload, with `OUT_READY` forced 0 for 3 cycles while beat addr 2 is valid:
  - `OUT_ADDR`=2 and `OUT_DATA`=8'h12 stay stable throughout;
  - DONE delayed by exactly 3 cycles;
  - no duplicate beats.
- Pulse START again at E4 during a dump: ignored, exactly 8 beats, one DONE.
- Assert RESET mid-cycle just after beat addr 3 is accepted:
  - `OUT_VALID`, `BUSY` and `OUT_DATA` go to 0 before the next edge;
  - no DONE;
  - a new START yields addr 0..7 from the beginning.
- Write r6=8'hAA while pair 1 is in SEND0, and r1=8'hBB at the same time:
  - beat addr 6 carries 8'hAA;
  - beat addr 1 carries the old 8'h11.
- Reset `reg_file` and `reg_dump` together, then START: 8 beats with data 8'h00, addresses 0..7.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// ============================================================================
// Module  : reg_dump_pkg
// Brief   : Shared state encoding and default geometry for reg_dump/reg_file.
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_dump_pkg;

  localparam int AW_DEF   = 3;
  localparam int DW_DEF   = 8;
  localparam int NREG_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    SEND0 = 3'd2,
    SEND1 = 3'd3,
    FIN   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_dump_if.sv
// ============================================================================
// Module  : reg_dump_if
// Brief   : Control, reg_file read port and beat stream seen by reg_dump.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface reg_dump_if
  import reg_dump_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          START;
  logic          BUSY;
  logic          DONE;
  logic [AW-1:0] READREG1;
  logic [AW-1:0] READREG2;
  logic [DW-1:0] REGOUT1;
  logic [DW-1:0] REGOUT2;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [AW-1:0] OUT_ADDR;
  logic [DW-1:0] OUT_DATA;

  modport master (
    input  START,
    output BUSY,
    output DONE,
    output READREG1,
    output READREG2,
    input  REGOUT1,
    input  REGOUT2,
    output OUT_VALID,
    input  OUT_READY,
    output OUT_ADDR,
    output OUT_DATA
  );

  modport slave (
    output START,
    input  BUSY,
    input  DONE,
    input  READREG1,
    input  READREG2,
    output REGOUT1,
    output REGOUT2,
    input  OUT_VALID,
    output OUT_READY,
    input  OUT_ADDR,
    input  OUT_DATA
  );

endinterface

`default_nettype wire

// File: rtl/reg_dump.sv
// ============================================================================
// Module  : reg_dump
// Brief   : Walks reg_file in register pairs and streams (addr, data) beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic      CLK,
  input  logic      RESET,
  reg_dump_if.master bus
);

  // Pair index: register addresses are {k, 0} and {k, 1}.
  localparam int            KW     = AW - 1;
  localparam logic [KW-1:0] K_LAST = KW'(NREG / 2 - 1);

  state_t        state;
  state_t        next_state;
  logic [KW-1:0] k;
  logic [KW-1:0] k_inc;
  logic          last_pair;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] buf0;
  logic [DW-1:0] buf1;

  logic          busy;
  logic          done;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  assign k_inc     = k + KW'(1);
  assign last_pair = (k == K_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Beat outputs decode from state and held registers only, so they never
  // depend on OUT_READY and stay stable while the consumer stalls.
  always_comb begin
    next_state = state;
    busy       = 1'b1;
    done       = 1'b0;
    out_valid  = 1'b0;
    out_addr   = '0;
    out_data   = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.START) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = SEND0;
      end
      SEND0: begin
        out_valid = 1'b1;
        out_addr  = {k, 1'b0};
        out_data  = buf0;
        if (bus.OUT_READY) begin
          next_state = SEND1;
        end
      end
      SEND1: begin
        out_valid = 1'b1;
        out_addr  = {k, 1'b1};
        out_data  = buf1;
        if (bus.OUT_READY) begin
          next_state = last_pair ? FIN : ISSUE;
        end
      end
      FIN: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

  // Read addresses are set up one edge ahead so they are stable for the whole
  // ISSUE cycle; the pair snapshot is taken on the edge leaving ISSUE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      k        <= '0;
      rd_addr1 <= '0;
      rd_addr2 <= '0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            k        <= '0;
            rd_addr1 <= '0;
            rd_addr2 <= AW'(1);
          end
        end
        ISSUE: begin
          buf0 <= bus.REGOUT1;
          buf1 <= bus.REGOUT2;
        end
        SEND1: begin
          if (bus.OUT_READY && !last_pair) begin
            k        <= k_inc;
            rd_addr1 <= {k_inc, 1'b0};
            rd_addr2 <= {k_inc, 1'b1};
          end
        end
        default: begin
          k <= k;
        end
      endcase
    end
  end

  assign bus.BUSY      = busy;
  assign bus.DONE      = done;
  assign bus.READREG1  = rd_addr1;
  assign bus.READREG2  = rd_addr2;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_ADDR  = out_addr;
  assign bus.OUT_DATA  = out_data;

endmodule

`default_nettype wire
